// File: rtl/accum_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine: 2-4 cycles per instruction, no backpressure (fixed-latency memory and ALU).
// Define ACU_ILLEGAL_TRAP_EN to halt on opcodes D-F; otherwise they execute as NOPs.
module accum_control_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        alu_op,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       acc,
  output logic [15:0]       ir,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] addr;
  } instr_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JUMP  = 4'h3;
  localparam logic [3:0] OP_JUMPZ = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_LOADI = 4'hC;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [15:0]         acc_q;
  instr_t              ir_q;
  instr_t              dec_instr;
  logic                halted_q;
  logic                store_we;
  logic                dec_illegal;

  function automatic logic is_mem_read(input logic [3:0] op);
    return (op == OP_LOAD) || (op >= OP_ADD && op <= OP_XOR);
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return 4'b0000;
      OP_SUB:  return 4'b0001;
      OP_SHL:  return 4'b0100;
      OP_SHR:  return 4'b0101;
      OP_AND:  return 4'b1000;
      OP_OR:   return 4'b1001;
      OP_XOR:  return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  // The fetched word is only on mem_rdata during DECODE; ir is loaded at the end of it.
  assign dec_instr   = instr_t'(mem_rdata);
  assign dec_illegal = (dec_instr.opcode > OP_LOADI);

  always_comb begin
    state_d  = state_q;
    mem_addr = '0;
    store_we = 1'b0;
    alu_op   = 4'b0000;
    unique case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH: begin
        mem_addr = 16'(pc_q);
        state_d  = DECODE;
      end
      DECODE: begin
`ifdef ACU_ILLEGAL_TRAP_EN
        if (dec_instr.opcode == OP_HALT || dec_illegal) state_d = HALTED;
`else
        if (dec_instr.opcode == OP_HALT) state_d = HALTED;
`endif
        else state_d = EXEC;
      end
      EXEC: begin
        alu_op = alu_code(ir_q.opcode);
        if (is_mem_read(ir_q.opcode)) begin
          mem_addr = 16'(ir_q.addr);
          state_d  = WB;
        end else if (ir_q.opcode == OP_STORE) begin
          mem_addr = 16'(ir_q.addr);
          store_we = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = FETCH;
        end
      end
      WB: begin
        alu_op  = alu_code(ir_q.opcode);
        state_d = FETCH;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // A reset edge must never commit a store, even mid-instruction.
  assign mem_we = store_we & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      acc_q    <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DECODE: begin
          ir_q <= dec_instr;
          pc_q <= pc_q + ADDR_W'(1);
          if (state_d == HALTED) halted_q <= 1'b1;
        end
        EXEC: begin
          case (ir_q.opcode)
            OP_JUMP:  pc_q <= ADDR_W'(ir_q.addr);
            OP_JUMPZ: if (acc_q == 16'h0000) pc_q <= ADDR_W'(ir_q.addr);
            OP_SHL:   acc_q <= {acc_q[14:0], 1'b0};
            OP_SHR:   acc_q <= {1'b0, acc_q[15:1]};
            OP_LOADI: acc_q <= {4'b0000, ir_q.addr};
            default:  ;
          endcase
        end
        WB: acc_q <= (ir_q.opcode == OP_LOAD) ? mem_rdata : alu_result;
        default: ;
      endcase
    end
  end

`ifdef ACU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else if (state_q == DECODE && dec_illegal) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = mem_rdata;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_accum_control_unit.sv
// Directed bench for accum_control_unit with a registered-read memory and combinational ALU model.
module tb_accum_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [11:0] pc;
  logic [15:0] acc, ir;
  logic [2:0]  st;
  logic        halted, illegal;

  logic [15:0] mem [0:4095];
  logic        tb_wr = 1'b0;
  logic [11:0] tb_waddr = '0;
  logic [15:0] tb_wdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc;

  accum_control_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .acc(acc), .ir(ir), .state(st), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    else if (tb_wr) mem[tb_waddr] <= tb_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
    tick;
    tb_wr = 1'b0;
  endtask

  task automatic hold_reset;
    reset = 1'b1; run = 1'b0;
    tick; tick;
  endtask

  task automatic start;
    reset = 1'b0; run = 1'b1;
    tick;
    run = 1'b0;
  endtask

  // Advance from one FETCH to the next; n = cycles the instruction took.
  task automatic step(input string tag, output int n);
    n = 0;
    do begin tick; n++; end while (st !== 3'd1 && n < 50);
    check(tag, {29'd0, st}, 32'd1);
  endtask

  task automatic wait_halt(input string tag, output int n);
    n = 0;
    while (halted !== 1'b1 && n < 200) begin tick; n++; end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b1;
    tick; tick;
    check("rst_state",  {29'd0, st}, 32'd0);
    check("rst_pc",     {20'd0, pc}, 32'd0);
    check("rst_acc",    {16'd0, acc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_we",     {31'd0, mem_we}, 32'd0);
    check("rst_addr",   {16'd0, mem_addr}, 32'd0);
    check("rst_aluop",  {28'd0, alu_op}, 32'd0);

    // Program 1: LOADI 5; ADD M[10]; STORE M[11]; HALT
    run = 1'b0;
    load(12'h000, 16'hC005); load(12'h001, 16'h5010);
    load(12'h002, 16'h2011); load(12'h003, 16'h0000);
    load(12'h010, 16'h0007); load(12'h011, 16'hDEAD);
    reset = 1'b0;
    tick; tick; tick;
    check("idle_hold", {29'd0, st}, 32'd0);
    start;
    check("p1_fetch", {29'd0, st}, 32'd1);
    wait_halt("p1_halt", cyc);
    check("p1_cycles", cyc, 32'd12);
    check("p1_mem11",  {16'd0, mem[12'h011]}, 32'h000C);
    check("p1_acc",    {16'd0, acc}, 32'h000C);
    check("p1_pc",     {20'd0, pc}, 32'h004);
    check("p1_state",  {29'd0, st}, 32'd5);
    run = 1'b1; tick; tick; run = 1'b0;
    check("p1_run_ignored", {29'd0, st}, 32'd5);

    // Program 2: branches and PC wrap
    hold_reset;
    load(12'h000, 16'hC000); load(12'h001, 16'h4020);
    load(12'h020, 16'hC001); load(12'h021, 16'h4030);
    load(12'h022, 16'h3FFF); load(12'hFFF, 16'h0000);
    start;
    step("p2_loadi0", cyc);
    check("p2_loadi_cyc", cyc, 32'd3);
    step("p2_jz_taken", cyc);
    check("p2_jz_pc", {20'd0, pc}, 32'h020);
    step("p2_loadi1", cyc);
    step("p2_jz_not", cyc);
    check("p2_jz_not_pc", {20'd0, pc}, 32'h022);
    check("p2_acc1", {16'd0, acc}, 32'h0001);
    step("p2_jump", cyc);
    check("p2_jump_pc", {20'd0, pc}, 32'hFFF);
    wait_halt("p2_halt", cyc);
    check("p2_wrap_pc", {20'd0, pc}, 32'h000);

    // Program 3: SUB underflow, shifts, logic ops
    hold_reset;
    load(12'h000, 16'hC003); load(12'h001, 16'h6040);
    load(12'h002, 16'h1041); load(12'h003, 16'hA000);
    load(12'h004, 16'hB000); load(12'h005, 16'h9042);
    load(12'h006, 16'h8043); load(12'h007, 16'h7044);
    load(12'h008, 16'h0000);
    load(12'h040, 16'h0005); load(12'h041, 16'h8001);
    load(12'h042, 16'h00FF); load(12'h043, 16'h0F00);
    load(12'h044, 16'h00F0);
    start;
    step("p3_loadi", cyc);
    tick; tick;
    check("p3_sub_exec_state", {29'd0, st}, 32'd3);
    check("p3_sub_addr",  {16'd0, mem_addr}, 32'h0040);
    check("p3_sub_aluop", {28'd0, alu_op}, 32'h1);
    tick;
    check("p3_sub_wb_state", {29'd0, st}, 32'd4);
    tick;
    check("p3_sub_acc", {16'd0, acc}, 32'hFFFE);
    step("p3_load", cyc);
    check("p3_load_cyc", cyc, 32'd4);
    check("p3_load_acc", {16'd0, acc}, 32'h8001);
    step("p3_shl", cyc);
    check("p3_shl_acc", {16'd0, acc}, 32'h0002);
    step("p3_shr", cyc);
    check("p3_shr_acc", {16'd0, acc}, 32'h0001);
    step("p3_xor", cyc);
    check("p3_xor_acc", {16'd0, acc}, 32'h00FE);
    step("p3_or", cyc);
    check("p3_or_acc", {16'd0, acc}, 32'h0FFE);
    step("p3_and", cyc);
    check("p3_and_acc", {16'd0, acc}, 32'h00F0);
    wait_halt("p3_halt", cyc);
    check("p3_pc", {20'd0, pc}, 32'h009);

    // Program 4: illegal opcode
    hold_reset;
    load(12'h000, 16'hD000); load(12'h001, 16'hC009); load(12'h002, 16'h0000);
    start;
`ifdef ACU_ILLEGAL_TRAP_EN
    wait_halt("p4_trap_halt", cyc);
    check("p4_trap_cyc",     cyc, 32'd2);
    check("p4_trap_illegal", {31'd0, illegal}, 32'd1);
    check("p4_trap_pc",      {20'd0, pc}, 32'h001);
    check("p4_trap_acc",     {16'd0, acc}, 32'h0000);
`else
    step("p4_nop", cyc);
    check("p4_nop_cyc", cyc, 32'd3);
    check("p4_nop_pc",  {20'd0, pc}, 32'h001);
    check("p4_nop_acc", {16'd0, acc}, 32'h0000);
    wait_halt("p4_halt", cyc);
    check("p4_acc",     {16'd0, acc}, 32'h0009);
    check("p4_illegal", {31'd0, illegal}, 32'd0);
    check("p4_pc",      {20'd0, pc}, 32'h003);
`endif

    // Program 5: reset lands on STORE's EXEC cycle
    hold_reset;
    load(12'h000, 16'hC00A); load(12'h001, 16'h2050); load(12'h050, 16'h1234);
    start;
    step("p5_loadi", cyc);
    tick; tick;
    check("p5_exec_state", {29'd0, st}, 32'd3);
    check("p5_store_we",   {31'd0, mem_we}, 32'd1);
    check("p5_store_addr", {16'd0, mem_addr}, 32'h0050);
    reset = 1'b1;
    #1;
    check("p5_we_gated", {31'd0, mem_we}, 32'd0);
    tick;
    reset = 1'b0;
    check("p5_mem_kept", {16'd0, mem[12'h050]}, 32'h1234);
    check("p5_state",    {29'd0, st}, 32'd0);
    check("p5_acc",      {16'd0, acc}, 32'h0000);
    check("p5_pc",       {20'd0, pc}, 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
